// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// wb_burst_master : sequences one N-beat read/write command as an
// incrementing Wishbone burst, with per-beat acknowledge timeout.
// Revision: 1.0
// ============================================================================
module wb_burst_master #(
    parameter int APP_AW      = 26,
    parameter int dw          = 32,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [dw/8-1:0]   cmd_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [dw-1:0]     wr_data,
    output logic              rd_valid,
    output logic [dw-1:0]     rd_data,
    output logic              done,
    output logic              err_timeout,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [dw/8-1:0]   wb_sel,
    output logic [APP_AW-1:0] wb_addr,
    output logic [dw-1:0]     wb_dati,
    output logic [2:0]        wb_cti,
    input  logic              wb_ack,
    input  logic [dw-1:0]     wb_dato
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [APP_AW-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [dw/8-1:0]     sel_q, sel_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]       to_q, to_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic [dw-1:0]       dati_q, dati_d;
    logic [2:0]          cti_q, cti_d;
    logic [dw-1:0]       rdat_q, rdat_d;
    logic                rval_q, rval_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    cnt_inc;

    // Burst type for beat idx of a len-beat command.
    function automatic logic [2:0] cti_for(input logic [LEN_W-1:0] len,
                                           input logic [LEN_W-1:0] idx);
        if (len == LEN_W'(1))
            return 3'b000;
        else if (idx == len - LEN_W'(1))
            return 3'b111;
        else
            return 3'b010;
    endfunction

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            dati_q  <= '0;
            cti_q   <= 3'b000;
            rdat_q  <= '0;
            rval_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            dati_q  <= dati_d;
            cti_q   <= cti_d;
            rdat_q  <= rdat_d;
            rval_q  <= rval_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        dati_d  = dati_q;
        cti_d   = cti_q;
        rdat_d  = rdat_q;
        rval_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d   = cmd_we;
                    addr_d = {cmd_addr[APP_AW-1:2], 2'b00};
                    len_d  = cmd_len;
                    sel_d  = cmd_sel;
                    cnt_d  = '0;
                    to_d   = '0;
                    cti_d  = cti_for(cmd_len, '0);
                    if (cmd_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (cmd_we) begin
                        state_d = WDATA;
                        cyc_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (wr_valid) begin
                    dati_d  = wr_data;
                    stb_d   = 1'b1;
                    to_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (wb_ack) begin
                    cnt_d  = cnt_inc;
                    addr_d = addr_q + APP_AW'(4);
                    to_d   = '0;
                    if (!we_q) begin
                        rdat_d = wb_dato;
                        rval_d = 1'b1;
                    end
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        cti_d   = 3'b000;
                    end else begin
                        cti_d = cti_for(len_q, cnt_inc);
                        if (we_q) begin
                            state_d = WDATA;
                            stb_d   = 1'b0;
                        end
                    end
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Abort: drop the remaining beats and go straight back to IDLE.
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    cti_d   = 3'b000;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign wr_ready    = (state_q == WDATA);
    assign rd_valid    = rval_q;
    assign rd_data     = rdat_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign wb_cyc      = cyc_q;
    assign wb_stb      = stb_q;
    assign wb_we       = we_q;
    assign wb_sel      = sel_q;
    assign wb_addr     = addr_q;
    assign wb_dati     = dati_q;
    assign wb_cti      = cti_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// tb_wb_burst_master : directed bench for wb_burst_master (TIMEOUT_CYC=16).
// Revision: 1.0
// ============================================================================
module tb_wb_burst_master;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [25:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done, err_timeout;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [25:0] wb_addr;
    logic [31:0] wb_dati;
    logic [2:0]  wb_cti;
    logic        wb_ack;
    logic [31:0] wb_dato;

    int total = 0;
    int bad   = 0;

    wb_burst_master #(
        .APP_AW(26), .dw(32), .LEN_W(8), .TIMEOUT_CYC(16)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err_timeout(err_timeout),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_addr(wb_addr), .wb_dati(wb_dati), .wb_cti(wb_cti),
        .wb_ack(wb_ack), .wb_dato(wb_dato)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [25:0] a, input logic [7:0] l,
                         input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_sel   = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [25:0] exp_addr [4];
    logic [2:0]  exp_cti  [4];
    int          n;

    initial begin
        wb_rst = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
        wr_valid = 0; wr_data = '0; wb_ack = 0; wb_dato = '0;
        tick(); tick();
        wb_rst = 1'b0;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_done", done, 0);

        // Single read, ack on the third strobe cycle
        issue(1'b0, 26'h0000103, 8'd1, 4'hF);
        chk("r1_cyc", wb_cyc, 1);
        chk("r1_stb", wb_stb, 1);
        chk("r1_addr", wb_addr, 26'h100);
        chk("r1_cti", wb_cti, 3'b000);
        chk("r1_we", wb_we, 0);
        chk("r1_cmd_ready", cmd_ready, 0);
        tick();
        tick();
        chk("r1_stb_wait", wb_stb, 1);
        chk("r1_no_rdv", rd_valid, 0);
        wb_ack = 1'b1; wb_dato = 32'hDEADBEEF;
        tick();
        wb_ack = 1'b0;
        chk("r1_rdv", rd_valid, 1);
        chk("r1_rdata", rd_data, 32'hDEADBEEF);
        chk("r1_done", done, 1);
        chk("r1_err", err_timeout, 0);
        chk("r1_cyc_low", wb_cyc, 0);
        chk("r1_stb_low", wb_stb, 0);
        tick();
        chk("r1_rdv_pulse", rd_valid, 0);
        chk("r1_done_pulse", done, 0);
        chk("r1_idle", cmd_ready, 1);

        // Read burst across the address wrap, ack every cycle
        exp_addr[0] = 26'h3FFFFF8; exp_cti[0] = 3'b010;
        exp_addr[1] = 26'h3FFFFFC; exp_cti[1] = 3'b010;
        exp_addr[2] = 26'h0000000; exp_cti[2] = 3'b010;
        exp_addr[3] = 26'h0000004; exp_cti[3] = 3'b111;
        issue(1'b0, 26'h3FFFFF8, 8'd4, 4'hF);
        wb_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_dato = 32'h1000 + i;
            chk("rb_addr", wb_addr, exp_addr[i]);
            chk("rb_cti", wb_cti, exp_cti[i]);
            chk("rb_stb", wb_stb, 1);
            tick();
            chk("rb_rdv", rd_valid, 1);
            chk("rb_rdata", rd_data, 32'h1000 + i);
            chk("rb_done", done, (i == 3) ? 1 : 0);
        end
        wb_ack = 1'b0;
        chk("rb_cyc_low", wb_cyc, 0);
        tick();

        // Write burst with a 5-cycle stall before beat 2
        issue(1'b1, 26'h40, 8'd3, 4'h5);
        chk("wb_cyc0", wb_cyc, 1);
        chk("wb_stb0", wb_stb, 0);
        chk("wb_wr_ready", wr_ready, 1);
        chk("wb_we", wb_we, 1);
        for (int b = 0; b < 3; b++) begin
            if (b == 1) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("wb_stall_cyc", wb_cyc, 1);
                    chk("wb_stall_stb", wb_stb, 0);
                end
            end
            wr_valid = 1'b1; wr_data = 32'hA0 + b;
            tick();
            wr_valid = 1'b0;
            chk("wb_stb", wb_stb, 1);
            chk("wb_dati", wb_dati, 32'hA0 + b);
            chk("wb_sel", wb_sel, 4'h5);
            chk("wb_addr", wb_addr, 26'h40 + 26'(4 * b));
            chk("wb_cti", wb_cti, (b == 2) ? 3'b111 : 3'b010);
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
            chk("wb_done", done, (b == 2) ? 1 : 0);
            chk("wb_cyc", wb_cyc, (b == 2) ? 0 : 1);
            chk("wb_no_rdv", rd_valid, 0);
        end
        tick();
        chk("wb_done_pulse", done, 0);

        // Zero-length command
        issue(1'b0, 26'h80, 8'd0, 4'hF);
        chk("z_done", done, 1);
        chk("z_cyc", wb_cyc, 0);
        chk("z_rdv", rd_valid, 0);
        tick();
        chk("z_done_pulse", done, 0);
        chk("z_cyc2", wb_cyc, 0);
        chk("z_idle", cmd_ready, 1);

        // Timeout on a 2-beat read with no ack
        issue(1'b0, 26'h200, 8'd2, 4'hF);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wb_stb) break;
            n++;
            tick();
        end
        chk("to_stb_cycles", n, 16);
        chk("to_done", done, 1);
        chk("to_err", err_timeout, 1);
        chk("to_cyc", wb_cyc, 0);
        tick();
        chk("to_err_pulse", err_timeout, 0);
        chk("to_idle", cmd_ready, 1);

        // Ack in the final timeout cycle wins
        issue(1'b0, 26'h300, 8'd1, 4'hF);
        chk("ta_cyc", wb_cyc, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("ta_stb", wb_stb, 1);
        wb_ack = 1'b1; wb_dato = 32'h5A5A5A5A;
        tick();
        wb_ack = 1'b0;
        chk("ta_done", done, 1);
        chk("ta_err", err_timeout, 0);
        chk("ta_rdv", rd_valid, 1);
        chk("ta_rdata", rd_data, 32'h5A5A5A5A);
        tick();

        // Asynchronous reset during beat 2 of a 4-beat write
        issue(1'b1, 26'h80, 8'd4, 4'hF);
        wr_valid = 1'b1; wr_data = 32'h11;
        tick();
        wr_valid = 1'b0;
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h22;
        tick();
        wr_valid = 1'b0;
        chk("ar_stb_before", wb_stb, 1);
        #2;
        wb_rst = 1'b1;
        #1;
        chk("ar_cyc", wb_cyc, 0);
        chk("ar_stb", wb_stb, 0);
        chk("ar_we", wb_we, 0);
        chk("ar_addr", wb_addr, 0);
        chk("ar_dati", wb_dati, 0);
        chk("ar_sel", wb_sel, 0);
        chk("ar_cti", wb_cti, 0);
        chk("ar_done", done, 0);
        tick();
        wb_rst = 1'b0;
        tick();
        chk("ar_done_after", done, 0);
        chk("ar_idle", cmd_ready, 1);
        chk("ar_cyc_after", wb_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone master stage directly upstream of the SDRAM controller's Wishbone slave port; drives wb_stb/wb_cyc/wb_we/wb_sel/wb_addr/wb_dati/wb_cti and consumes wb_ack/wb_dato.
- Accepts one read or write command of N 32-bit beats and sequences it as an incrementing Wishbone burst.
- Streams write data in from an upstream source and returns read data to an upstream sink.
- Reports completion, and aborts the command if the slave fails to acknowledge a beat.

Parameters:
- APP_AW, 26: application (byte) address width.
- dw, 32: Wishbone data width.
- LEN_W, 8: width of the beat-count field.
- TIMEOUT_CYC, 1024: cycles allowed with wb_stb high and no wb_ack before abort.

Ports:
- wb_clk in 1: Wishbone clock; single clock domain.
- wb_rst in 1: reset, asynchronous, active-high.
- cmd_valid in 1: command offered.
- cmd_ready out 1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_we in 1: 1 = write, 0 = read.
- cmd_addr in APP_AW: start byte address; bits [1:0] are ignored and driven 0 on the bus.
- cmd_len in LEN_W: number of beats; 0 is legal.
- cmd_sel in dw/8: byte select applied to every beat.
- wr_valid in 1: write data offered.
- wr_ready out 1: write data taken when wr_valid and wr_ready are both high.
- wr_data in dw: write beat data.
- rd_valid out 1: one-cycle pulse carrying a read beat; no backpressure.
- rd_data out dw: read beat data.
- done out 1: one-cycle pulse when a command ends, normally or by abort.
- err_timeout out 1: one-cycle pulse, coincident with done, on abort.
- wb_cyc out 1: Wishbone cycle.
- wb_stb out 1: Wishbone strobe.
- wb_we out 1: Wishbone write enable.
- wb_sel out dw/8: Wishbone byte select.
- wb_addr out APP_AW: Wishbone address.
- wb_dati out dw: Wishbone write data (into the slave).
- wb_cti out 3: Wishbone cycle type identifier.
- wb_ack in 1: Wishbone acknowledge.
- wb_dato in dw: Wishbone read data (from the slave).

Behaviour:
- Reset: wb_rst asynchronously clears all outputs and registers to 0 and forces state IDLE, including mid-burst. The in-flight command is discarded with no done pulse.
- All bus outputs, rd_valid, rd_data, done and err_timeout are registered.
- cmd_ready = (state==IDLE). wr_ready = (state==WDATA).
- IDLE: on command handshake, latch we/addr/len/sel and clear the beat counter, then:
  - len==0 -> DONE, with no bus activity.
  - write -> WDATA; wb_cyc=1 and wb_stb=0 from the next cycle.
  - read -> REQ; wb_cyc=wb_stb=1 from the next cycle.
- WDATA: on wr_valid, register wr_data into wb_dati and go to REQ; wb_stb rises on the next cycle. There is no timeout in this state, and wb_cyc stays high while waiting.
- REQ: wb_stb=wb_cyc=1. wb_we, wb_sel and wb_addr are stable until wb_ack. On wb_ack:
  - Increment the beat counter and advance wb_addr by 4, wrapping modulo 2^APP_AW.
  - On a read, register wb_dato into rd_data and pulse rd_valid on the next cycle.
  - Last beat -> DONE, with wb_stb and wb_cyc low from the next cycle.
  - Read, not last -> stay in REQ with wb_stb held high (back-to-back).
  - Write, not last -> WDATA, with wb_stb low and wb_cyc held high.
- wb_cti:
  - 3'b000 when len==1.
  - Otherwise 3'b010 for every beat except the last.
  - 3'b111 on the last beat.
- wb_ack while wb_stb is low is ignored.
- Timeout: the counter clears on entry to REQ and on every wb_ack, and increments each REQ cycle without wb_ack. At TIMEOUT_CYC-1 with no ack: wb_stb and wb_cyc drop on the next edge, done and err_timeout pulse together, the remaining beats are dropped, and the state returns to IDLE. A wb_ack in the same cycle as the timeout wins, and the beat completes normally.
- DONE: done=1 for one cycle, then IDLE. A new command is accepted at the earliest one cycle after done.
- Read latency: if cmd is accepted at edge 0 and wb_ack is sampled at edge k, then rd_valid is high in the cycle after edge k. For the final beat, done is high in that same cycle.
- Write burst throughput: at most one beat per 2 cycles, because of the WDATA step.

Test Plan:
- Single read: cmd addr=0x0000100, len=1, slave acks on 3rd stb cycle with wb_dato=0xDEADBEEF -> wb_cti=000, wb_addr=0x100, one rd_valid with 0xDEADBEEF, done coincident, wb_cyc low afterward.
- Read burst: len=4, addr=0x3FFFFF8, slave acks every cycle -> wb_addr sequence 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004; cti 010,010,010,111; four rd_valid pulses; wb_stb continuous.
- Write burst with stall: len=3, addr=0x40, wr_valid withheld 5 cycles before beat 2 -> wb_cyc stays high, wb_stb low during stall, wb_dati/wb_sel match each beat, one done.
- len=0 command -> done one cycle after accept, wb_cyc never asserts, no rd_valid.
- Timeout: TIMEOUT_CYC=16, read len=2, no ack -> wb_stb high exactly 16 cycles, then done+err_timeout pulse together, bus idle, next cmd accepted.
- Async reset mid-burst: assert wb_rst between edges during beat 2 of a 4-beat write -> all outputs 0 immediately, no done; after release, IDLE with cmd_ready=1.
